// File: rtl/watch_pkg.sv
// watch_pkg: shared types, BCD limits and the BCD increment helper for the
// alarm-watch timekeeper.
//   mode_t      front-panel mode (RUN, SET_TIME, SET_ALARM; 2'b11 behaves as RUN)
//   alarm_st_t  alarm ring/snooze state
//   bcd_inc     returns {wrap, next} for a 2-digit BCD value with a given maximum
package watch_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } alarm_st_t;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // Bit 8 of the result flags a wrap back to 00; the low byte is the next value.
  function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [8:0] res;
    if (val == max)
      res = 9'h100;
    else if (val[3:0] == 4'd9)
      res = {1'b0, val[7:4] + 4'd1, 4'd0};
    else
      res = {1'b0, val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: 2-digit BCD counter that wraps from MAX to 00.
//   clk, rstn   clock and asynchronous active-low reset
//   en          chained count enable (carry in from the lower field)
//   inc         manual step from a button; never produces a carry
//   load_zero   synchronous clear, takes priority over counting
//   value       current BCD value
//   carry       high when an en-driven step wraps MAX -> 00
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter logic [7:0] MAX = SEC_MAX
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       inc,
  input  logic       load_zero,
  output logic [7:0] value,
  output logic       carry
);

  logic [8:0] step;

  assign step = bcd_inc(value, MAX);

  // Only chained counting ripples upward; button edits wrap within the field.
  assign carry = en && step[8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      value <= '0;
    else if (load_zero)
      value <= '0;
    else if (en || inc)
      value <= step[7:0];
  end

endmodule

// File: rtl/watch_timekeeper.sv
// watch_timekeeper: time-of-day core of the alarm watch.
//   clk, rstn            system clock, asynchronous active-low reset
//   mode                 00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 as RUN
//   inc_hr, inc_min      single-cycle edit pulses for the field picked by mode
//   alarm_en             alarm armed (level)
//   snooze, stop         single-cycle pulses from the debouncer
//   hh/mm/ss_bcd         current time in BCD
//   al_hh/al_mm_bcd      alarm time in BCD
//   sec_tick             one-cycle pulse per second while time is running
//   ringing              registered alarm output
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MIN = 5,
  parameter logic [7:0] AL_HH_RST  = 8'h07
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] mode,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [7:0] al_hh_bcd,
  output logic [7:0] al_mm_bcd,
  output logic       sec_tick,
  output logic       ringing
);

  localparam int PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int CNT_MAX      = (RING_SEC > SNOOZE_TICKS) ? RING_SEC : SNOOZE_TICKS;
  localparam int CW           = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [CW-1:0] RING_LAST   = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_TICKS - 1);

  logic          set_time;
  logic          set_alarm;
  logic [PW-1:0] presc;
  logic          ss_carry;
  logic          mm_carry;
  logic          hh_carry_unused;
  logic [7:0]    al_hh_step;
  logic [7:0]    al_mm_step;
  logic [1:0]    al_wrap_unused;
  logic          tick_d;
  logic          alarm_hit;
  logic [CW-1:0] cnt;
  alarm_st_t     state;

  assign set_time  = (mode == SET_TIME);
  assign set_alarm = (mode == SET_ALARM);

  // Prescaler is parked at 0 while the time is being edited so the first
  // second after leaving SET_TIME is a full one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      presc <= '0;
    else if (set_time || presc == PRESC_LAST)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  assign sec_tick = !set_time && (presc == PRESC_LAST);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clk       (clk),
    .rstn      (rstn),
    .en        (sec_tick),
    .inc       (1'b0),
    .load_zero (set_time),
    .value     (ss_bcd),
    .carry     (ss_carry)
  );

  bcd_mod_counter #(.MAX(SEC_MAX)) u_mm (
    .clk       (clk),
    .rstn      (rstn),
    .en        (ss_carry),
    .inc       (set_time && inc_min),
    .load_zero (1'b0),
    .value     (mm_bcd),
    .carry     (mm_carry)
  );

  // Midnight rollover has no consumer; the hours carry is left dangling.
  bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
    .clk       (clk),
    .rstn      (rstn),
    .en        (mm_carry),
    .inc       (set_time && inc_hr),
    .load_zero (1'b0),
    .value     (hh_bcd),
    .carry     (hh_carry_unused)
  );

  assign {al_wrap_unused[1], al_hh_step} = bcd_inc(al_hh_bcd, HR_MAX);
  assign {al_wrap_unused[0], al_mm_step} = bcd_inc(al_mm_bcd, SEC_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      al_hh_bcd <= AL_HH_RST;
      al_mm_bcd <= 8'h00;
    end else if (set_alarm) begin
      if (inc_hr)
        al_hh_bcd <= al_hh_step;
      if (inc_min)
        al_mm_bcd <= al_mm_step;
    end
  end

  // The match is only looked at in the cycle right after a tick, so sitting
  // at hh:mm:00 (or editing into it) never re-triggers the alarm.
  assign alarm_hit = tick_d && (hh_bcd == al_hh_bcd) && (mm_bcd == al_mm_bcd) &&
                     (ss_bcd == 8'h00);

  // Ring/snooze controller; cnt counts seconds within RINGING or SNOOZE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ringing <= 1'b0;
      cnt     <= '0;
      tick_d  <= 1'b0;
    end else begin
      tick_d <= sec_tick;
      if (!alarm_en || set_time) begin
        state   <= IDLE;
        ringing <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (alarm_hit) begin
              state   <= RINGING;
              ringing <= 1'b1;
              cnt     <= '0;
            end
          end
          RINGING: begin
            if (stop) begin
              state   <= IDLE;
              ringing <= 1'b0;
              cnt     <= '0;
            end else if (snooze) begin
              state   <= SNOOZE;
              ringing <= 1'b0;
              cnt     <= '0;
            end else if (sec_tick) begin
              if (cnt == RING_LAST) begin
                state   <= IDLE;
                ringing <= 1'b0;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          SNOOZE: begin
            if (stop) begin
              state   <= IDLE;
              ringing <= 1'b0;
              cnt     <= '0;
            end else if (sec_tick) begin
              if (cnt == SNOOZE_LAST) begin
                state   <= RINGING;
                ringing <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            ringing <= 1'b0;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_timekeeper.sv
// tb_watch_timekeeper: directed bench for watch_timekeeper with a fast
// prescaler (4 clocks per second), 3-second ring and 1-minute snooze.
module tb_watch_timekeeper;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] mode;
  logic       inc_hr;
  logic       inc_min;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic [7:0] al_hh_bcd;
  logic [7:0] al_mm_bcd;
  logic       sec_tick;
  logic       ringing;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic       hr;
    logic       mn;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       tick;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  watch_timekeeper #(
    .CLK_HZ     (4),
    .RING_SEC   (3),
    .SNOOZE_MIN (1),
    .AL_HH_RST  (8'h07)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (mode),
    .inc_hr    (inc_hr),
    .inc_min   (inc_min),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .stop      (stop),
    .hh_bcd    (hh_bcd),
    .mm_bcd    (mm_bcd),
    .ss_bcd    (ss_bcd),
    .al_hh_bcd (al_hh_bcd),
    .al_mm_bcd (al_mm_bcd),
    .sec_tick  (sec_tick),
    .ringing   (ringing)
  );

  // Drive the mode and edit buttons for the next clock edge.
  task automatic applyStimulus(input logic [1:0] m, input logic hr, input logic mn);
    mode    = m;
    inc_hr  = hr;
    inc_min = mn;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkTime(input string name, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s);
    checkOutput({name, "_hh"}, hh_bcd, h);
    checkOutput({name, "_mm"}, mm_bcd, m);
    checkOutput({name, "_ss"}, ss_bcd, s);
  endtask

  // Hold the current stimulus for n edges, noting any sec_tick seen.
  task automatic runCycles(input int n, output logic tick_seen);
    tick_seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (sec_tick) tick_seen = 1'b1;
    end
  endtask

  // Wait for ringing to rise, giving up after max_cycles.
  task automatic waitRing(input string name, input int max_cycles);
    int w;
    w = 0;
    while (ringing !== 1'b1 && w < max_cycles) begin
      @(negedge clk);
      w++;
    end
    checkBit(name, ringing, 1'b1);
  endtask

  initial begin
    logic seen;
    logic any_ring;

    vecs[0] = '{2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 1'b0};
    vecs[1] = '{2'b01, 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h07, 8'h00, 1'b0};
    vecs[3] = '{2'b01, 1'b1, 1'b1, 8'h02, 8'h02, 8'h00, 8'h07, 8'h00, 1'b0};
    vecs[4] = '{2'b10, 1'b1, 1'b0, 8'h02, 8'h02, 8'h00, 8'h08, 8'h00, 1'b0};
    vecs[5] = '{2'b10, 1'b0, 1'b1, 8'h02, 8'h02, 8'h00, 8'h08, 8'h01, 1'b0};
    vecs[6] = '{2'b10, 1'b1, 1'b1, 8'h02, 8'h02, 8'h00, 8'h09, 8'h02, 1'b1};
    vecs[7] = '{2'b00, 1'b1, 1'b1, 8'h02, 8'h02, 8'h01, 8'h09, 8'h02, 1'b0};
    vecs[8] = '{2'b11, 1'b1, 1'b1, 8'h02, 8'h02, 8'h01, 8'h09, 8'h02, 1'b0};
    vecs[9] = '{2'b01, 1'b0, 1'b1, 8'h02, 8'h03, 8'h00, 8'h09, 8'h02, 1'b0};

    rstn     = 1'b0;
    alarm_en = 1'b0;
    snooze   = 1'b0;
    stop     = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0);

    // Reset values, then the tick cadence after release.
    repeat (2) @(negedge clk);
    checkTime("reset", 8'h00, 8'h00, 8'h00);
    checkOutput("reset_al_hh", al_hh_bcd, 8'h07);
    checkOutput("reset_al_mm", al_mm_bcd, 8'h00);
    checkBit("reset_tick", sec_tick, 1'b0);
    checkBit("reset_ring", ringing, 1'b0);
    rstn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkBit($sformatf("tick_c%0d", i), sec_tick, (i % 4) == 3);
    end
    checkOutput("tick_ss", ss_bcd, 8'h03);

    // Table of edit vectors, one clock edge each.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].hr, vecs[i].mn);
      @(negedge clk);
      checkTime($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss);
      checkOutput($sformatf("vec%0d_al_hh", i), al_hh_bcd, vecs[i].al_hh);
      checkOutput($sformatf("vec%0d_al_mm", i), al_mm_bcd, vecs[i].al_mm);
      checkBit($sformatf("vec%0d_tick", i), sec_tick, vecs[i].tick);
    end

    // SET_TIME wraps without carrying between fields.
    applyStimulus(2'b01, 1'b0, 1'b1);
    runCycles(56, seen);
    checkTime("set_mm59", 8'h02, 8'h59, 8'h00);
    checkBit("set_tick_a", seen, 1'b0);
    runCycles(1, seen);
    checkTime("set_mm_wrap", 8'h02, 8'h00, 8'h00);
    applyStimulus(2'b01, 1'b1, 1'b0);
    runCycles(21, seen);
    checkTime("set_hh23", 8'h23, 8'h00, 8'h00);
    checkBit("set_tick_b", seen, 1'b0);
    runCycles(1, seen);
    checkTime("set_hh_wrap", 8'h00, 8'h00, 8'h00);

    // Midnight rollover from 23:59:00.
    runCycles(23, seen);
    applyStimulus(2'b01, 1'b0, 1'b1);
    runCycles(59, seen);
    checkTime("roll_start", 8'h23, 8'h59, 8'h00);
    applyStimulus(2'b00, 1'b0, 1'b0);
    runCycles(236, seen);
    checkTime("roll_59", 8'h23, 8'h59, 8'h59);
    runCycles(3, seen);
    checkTime("roll_hold", 8'h23, 8'h59, 8'h59);
    runCycles(1, seen);
    checkTime("roll_mid", 8'h00, 8'h00, 8'h00);

    // Alarm at 00:01 from 09:02, then ring and auto-stop.
    applyStimulus(2'b10, 1'b1, 1'b0);
    runCycles(1, seen);
    checkOutput("al_hh_10", al_hh_bcd, 8'h10);
    runCycles(14, seen);
    checkOutput("al_hh_00", al_hh_bcd, 8'h00);
    applyStimulus(2'b10, 1'b0, 1'b1);
    runCycles(59, seen);
    checkOutput("al_mm_01", al_mm_bcd, 8'h01);
    applyStimulus(2'b01, 1'b0, 1'b0);
    runCycles(1, seen);
    checkTime("alarm_start", 8'h00, 8'h00, 8'h00);
    alarm_en = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (c == 240) checkTime("alarm_0100", 8'h00, 8'h01, 8'h00);
      checkBit($sformatf("ring1_c%0d", c), ringing, (c >= 241) && (c <= 251));
    end

    // Snooze, re-ring after 60 ticks, then stop beats snooze.
    applyStimulus(2'b10, 1'b0, 1'b1);
    runCycles(1, seen);
    checkOutput("al_mm_02", al_mm_bcd, 8'h02);
    applyStimulus(2'b00, 1'b0, 1'b0);
    waitRing("ring2_rise", 400);
    checkTime("ring2_time", 8'h00, 8'h02, 8'h00);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    checkBit("snooze_drop", ringing, 1'b0);
    for (int j = 1; j <= 238; j++) begin
      @(negedge clk);
      checkBit($sformatf("snooze_j%0d", j), ringing, j == 238);
    end
    snooze = 1'b1;
    stop   = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    stop   = 1'b0;
    checkBit("stop_wins", ringing, 1'b0);
    any_ring = 1'b0;
    repeat (260) begin
      @(negedge clk);
      if (ringing) any_ring = 1'b1;
    end
    checkBit("stop_stays", any_ring, 1'b0);

    // Fresh reset, ring at 00:01, then reset in the middle of the ring.
    alarm_en = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(2'b10, 1'b1, 1'b0);
    runCycles(17, seen);
    checkOutput("al3_hh", al_hh_bcd, 8'h00);
    applyStimulus(2'b10, 1'b0, 1'b1);
    runCycles(1, seen);
    checkOutput("al3_mm", al_mm_bcd, 8'h01);
    applyStimulus(2'b01, 1'b0, 1'b0);
    runCycles(1, seen);
    checkTime("ring3_start", 8'h00, 8'h00, 8'h00);
    alarm_en = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    waitRing("ring3_rise", 300);
    #1;
    rstn = 1'b0;
    #1;
    checkBit("async_ring", ringing, 1'b0);
    checkTime("async", 8'h00, 8'h00, 8'h00);
    checkOutput("async_al_hh", al_hh_bcd, 8'h07);
    checkOutput("async_al_mm", al_mm_bcd, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkBit("post_reset_ring", ringing, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
